neo_frame_sequencer: RTL and testbench

//  Owns the NeoPixel strip contents for the game board and sequences the bit-level NeoPixel driver.

---
 rtl/neo_frame_sequencer_if.sv | 28 ++
 rtl/neo_frame_sequencer.sv | 121 ++++++++++++
 tb/tb_neo_frame_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/neo_frame_sequencer_if.sv
// Pixel-load, frame-request and GRB word stream signals between game logic, sequencer and driver.
// master = sequencer side; slave = the controls/driver side that feeds it and consumes words.
interface neo_frame_sequencer_if #(
  parameter int NUM_PIXELS = 4
);
  localparam int LOC_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

  logic [2:0]       color_to_load;
  logic [LOC_W-1:0] color_location;
  logic             load_color;
  logic             display;
  logic [23:0]      pix_data;
  logic             pix_valid;
  logic             pix_ready;
  logic             latch;
  logic             busy;
  logic             done;

  modport master (
    input  color_to_load, color_location, load_color, display, pix_ready,
    output pix_data, pix_valid, latch, busy, done
  );

  modport slave (
    output color_to_load, color_location, load_color, display, pix_ready,
    input  pix_data, pix_valid, latch, busy, done
  );
endinterface

// File: rtl/neo_frame_sequencer.sv
// NeoPixel frame sequencer: per-pixel colour slots, snapshot, GRB word stream, latch gap. Optional NEO_AUTO_REFRESH_EN.
// First word 1 cycle after start; words held while pix_valid && !pix_ready; done NUM_PIXELS+LATCH_CYCLES+1 after display.
module neo_frame_sequencer #(
  parameter int NUM_PIXELS   = 4,
  parameter int LATCH_CYCLES = 2500
) (
  input  logic                    clock,
  input  logic                    reset_L,
  neo_frame_sequencer_if.master   bus
);
  localparam int IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, SEND, LATCH, DONE} state_t;

  state_t           state, state_nxt;
  logic [2:0]       slots     [NUM_PIXELS];
  logic [2:0]       slots_nxt [NUM_PIXELS];
  logic [2:0]       snap      [NUM_PIXELS];
  logic [2:0]       snap_nxt  [NUM_PIXELS];
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pending, pending_nxt;
  logic             wr_en, wr_dirty, consume, accept;

  function automatic logic [23:0] decode(input logic [2:0] code);
    case (code)
      3'd1:    decode = 24'h002000;
      3'd2:    decode = 24'h200000;
      3'd3:    decode = 24'h000020;
      3'd4:    decode = 24'h202000;
      3'd5:    decode = 24'h002020;
      3'd6:    decode = 24'h200020;
      3'd7:    decode = 24'h202020;
      default: decode = 24'h000000;
    endcase
  endfunction

  always_comb begin
    wr_en     = bus.load_color && (int'(bus.color_location) < NUM_PIXELS);
    slots_nxt = slots;
    if (wr_en) slots_nxt[bus.color_location] = bus.color_to_load;
`ifdef NEO_AUTO_REFRESH_EN
    wr_dirty  = wr_en;
`else
    wr_dirty  = 1'b0;
`endif
  end

  // Snapshot reads slots_nxt so a write landing on the start edge is included.
  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    consume   = 1'b0;
    accept    = (state == SEND) && bus.pix_ready;
    case (state)
      IDLE: begin
        if (bus.display || pending) begin
          state_nxt = SEND;
          snap_nxt  = slots_nxt;
          idx_nxt   = '0;
          consume   = 1'b1;
        end
      end
      SEND: begin
        if (accept) begin
          if (idx == IDX_W'(NUM_PIXELS - 1)) begin
            state_nxt = LATCH;
            cnt_nxt   = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      LATCH: begin
        if (cnt == CNT_W'(LATCH_CYCLES - 1)) state_nxt = DONE;
        else                                 cnt_nxt   = cnt + 1'b1;
      end
      DONE: begin
        if (pending) begin
          state_nxt = SEND;
          snap_nxt  = slots_nxt;
          idx_nxt   = '0;
          consume   = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = (pending && !consume) || (bus.display && (state != IDLE)) || wr_dirty;
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      pending <= 1'b0;
      for (int i = 0; i < NUM_PIXELS; i++) begin
        slots[i] <= '0;
        snap[i]  <= '0;
      end
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      slots   <= slots_nxt;
      snap    <= snap_nxt;
    end
  end

  assign bus.pix_valid = (state == SEND);
  assign bus.pix_data  = (state == SEND) ? decode(snap[idx]) : 24'h000000;
  assign bus.latch     = (state == LATCH);
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_neo_frame_sequencer.sv
// Bench for neo_frame_sequencer: decode table, frame timing, stall hold, pending merge, async reset, auto refresh.
module tb_neo_frame_sequencer;
  localparam int N = 4;
  localparam int L = 10;

  typedef struct {
    logic [2:0]  code;
    logic [23:0] exp;
  } vec_t;

  logic clock = 1'b0;
  logic reset_L = 1'b0;
  always #5 clock = ~clock;

  neo_frame_sequencer_if #(.NUM_PIXELS(N)) bus ();
  neo_frame_sequencer #(.NUM_PIXELS(N), .LATCH_CYCLES(L)) dut (
    .clock(clock), .reset_L(reset_L), .bus(bus)
  );

  vec_t        tbl [8];
  logic [2:0]  mdl [N];
  logic [23:0] exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, first_valid = -1, last_acc = 0;
  int acc_frame = 0, frame_words = 0, latch_cnt = 0, last_latch = 0, stall_cnt = 0;
  logic        prev_stall = 1'b0;
  logic [23:0] prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no-event", name);
  endtask

  function automatic logic [23:0] exp_of(input logic [2:0] code);
    exp_of = 24'hxxxxxx;
    for (int i = 0; i < 8; i++) if (tbl[i].code == code) exp_of = tbl[i].exp;
  endfunction

  always @(posedge clock) cyc++;

  // Scoreboard consumer and per-frame bookkeeping, sampled mid-cycle.
  always @(negedge clock) begin
    if (reset_L) begin
      if (bus.pix_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (prev_stall) check("hold_data", {8'h0, bus.pix_data}, {8'h0, prev_data});
        if (bus.pix_ready) begin
          if (exp_q.size() == 0) fail_now("unexpected_word");
          else check("word", {8'h0, bus.pix_data}, {8'h0, exp_q.pop_front()});
          acc_frame++;
          last_acc = cyc;
        end else begin
          stall_cnt++;
        end
      end else if (prev_stall) begin
        fail_now("valid_dropped_in_stall");
      end
      prev_stall = bus.pix_valid && !bus.pix_ready;
      prev_data  = bus.pix_data;
      if (bus.latch) latch_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_cyc    = cyc;
        last_latch  = latch_cnt;
        frame_words = acc_frame;
        latch_cnt   = 0;
        acc_frame   = 0;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int loc, input logic [2:0] code);
    bus.color_location = loc[1:0];
    bus.color_to_load  = code;
    bus.load_color     = 1'b1;
    mdl[loc]           = code;
    step();
    bus.load_color     = 1'b0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < N; i++) exp_q.push_back(exp_of(mdl[i]));
  endtask

  task automatic pulse();
    bus.display = 1'b1;
    step();
    bus.display = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clock);
      #2;
      if (done_cnt > d0) seen = 1;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  initial begin
    int t0, d0;
    bit hit;
    tbl[0] = '{3'd1, 24'h002000}; tbl[1] = '{3'd2, 24'h200000};
    tbl[2] = '{3'd3, 24'h000020}; tbl[3] = '{3'd7, 24'h202020};
    tbl[4] = '{3'd0, 24'h000000}; tbl[5] = '{3'd4, 24'h202000};
    tbl[6] = '{3'd5, 24'h002020}; tbl[7] = '{3'd6, 24'h200020};
    for (int i = 0; i < N; i++) mdl[i] = 3'd0;
    bus.color_to_load = '0; bus.color_location = '0; bus.load_color = 1'b0;
    bus.display = 1'b0; bus.pix_ready = 1'b1;

    repeat (3) @(posedge clock);
    #2;
    check("rst_valid", {31'h0, bus.pix_valid}, 0);
    check("rst_latch", {31'h0, bus.latch}, 0);
    check("rst_busy",  {31'h0, bus.busy}, 0);
    check("rst_done",  {31'h0, bus.done}, 0);
    check("rst_data",  {8'h0, bus.pix_data}, 0);
    reset_L = 1'b1;
    step();

    // Empty slots: timing of first word, last accept and done.
    first_valid = -1;
    t0 = cyc;
    push_frame();
    pulse();
    wait_done(100);
    check("first_valid_lat", first_valid - t0, 1);
    check("last_accept_lat", last_acc - t0, N);
    check("done_lat", done_cyc - t0, N + L + 1);
    check("latch_len", last_latch, L);
    check("q_empty_b", exp_q.size(), 0);

`ifndef NEO_AUTO_REFRESH_EN
    // Decode table applied as two frames of four slots.
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < N; i++) load(i, tbl[f * N + i].code);
      for (int i = 0; i < N; i++) exp_q.push_back(tbl[f * N + i].exp);
      pulse();
      wait_done(100);
      check("tbl_latch_len", last_latch, L);
      check("tbl_words", frame_words, N);
      check("q_empty_tbl", exp_q.size(), 0);
    end

    // Driver stalls five cycles on word 2.
    push_frame();
    stall_cnt = 0;
    pulse();
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (acc_frame >= 2) hit = 1;
      else step();
    end
    if (!hit) fail_now("stall_setup_timeout");
    bus.pix_ready = 1'b0;
    repeat (5) step();
    bus.pix_ready = 1'b1;
    wait_done(100);
    check("stall_cycles", stall_cnt, 5);
    check("stall_words", frame_words, N);
    check("q_empty_stall", exp_q.size(), 0);

    // Mid-SEND write and two merged displays: one extra frame, back to back.
    push_frame();
    pulse();
    bus.display = 1'b1;
    load(0, 3'd5);
    push_frame();
    pulse();
    wait_done(100);
    check("merge_first_words", frame_words, N);
    check("rerun_starts_after_done", {31'h0, bus.pix_valid}, 1);
    wait_done(100);
    check("merge_second_words", frame_words, N);
    d0 = done_cnt;
    repeat (3 * (N + L)) step();
    check("merge_no_third", done_cnt, d0);
    check("merge_idle", {31'h0, bus.busy}, 0);
    check("q_empty_merge", exp_q.size(), 0);
`endif

    // Asynchronous reset while in the latch gap.
    push_frame();
    pulse();
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      if (bus.latch) hit = 1;
      else step();
    end
    if (!hit) fail_now("latch_wait_timeout");
    #2;
    reset_L = 1'b0;
    #1;
    check("arst_valid", {31'h0, bus.pix_valid}, 0);
    check("arst_latch", {31'h0, bus.latch}, 0);
    check("arst_busy",  {31'h0, bus.busy}, 0);
    check("arst_done",  {31'h0, bus.done}, 0);
    check("arst_data",  {8'h0, bus.pix_data}, 0);
    check("q_empty_arst", exp_q.size(), 0);
    for (int i = 0; i < N; i++) mdl[i] = 3'd0;
    latch_cnt = 0;
    acc_frame = 0;
    step();
    reset_L = 1'b1;
    step();
    push_frame();
    pulse();
    wait_done(100);
    check("post_rst_words", frame_words, N);
    check("q_empty_post_rst", exp_q.size(), 0);

    // Slot write in IDLE with no display.
`ifdef NEO_AUTO_REFRESH_EN
    first_valid = -1;
    t0 = cyc;
    load(3, 3'd6);
    push_frame();
    wait_done(100);
    check("auto_start_lat", first_valid - t0, 2);
    check("auto_words", frame_words, N);
    check("q_empty_auto", exp_q.size(), 0);
`else
    d0 = done_cnt;
    load(3, 3'd6);
    repeat (2 * (N + L)) step();
    check("no_auto_frame", done_cnt, d0);
    check("no_auto_busy", {31'h0, bus.busy}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
